// File: rtl/folded_fir_pkg.sv
// Shared constants and types for the five-tap folded FIR.
// One multiplier is time-shared across all taps, so the fold factor equals NTAP.
package folded_fir_pkg;
   localparam int NTAP  = 5;
   localparam int DW    = 8;
   localparam int CW    = 12;
   localparam int OW    = 22;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int PW    = DW + CW;

   typedef logic signed [DW-1:0] sample_t;
   typedef logic signed [CW-1:0] coef_t;
   typedef logic signed [OW-1:0] acc_t;
   typedef logic signed [PW-1:0] prod_t;

   // Sign-extend a tap product to accumulator width.
   function automatic acc_t prod_to_acc(input prod_t p);
      return acc_t'(p);
   endfunction
endpackage

// File: rtl/top_folded_fir_mem.sv
// Sample ROM with a combinational read port.
// The contents are preloaded from outside the design through DIRECT_INPUT_MEM.array.
module direct_input_mem
   import folded_fir_pkg::*;
(
   input  logic [AW-1:0] i_addr,
   output sample_t       o_data
);
   sample_t array [DEPTH];

   assign o_data = array[i_addr];
endmodule

// File: rtl/top_folded_fir.sv
// Five-tap folded FIR: one sample every five cycles, one multiply per cycle.
// The c4*x4 term is folded into the output write on the same edge as the next shift.
module top_folded_fir
   import folded_fir_pkg::*;
(
   input  logic                 clk100,
   input  logic                 rst,
   input  logic signed [CW-1:0] c0,
   input  logic signed [CW-1:0] c1,
   input  logic signed [CW-1:0] c2,
   input  logic signed [CW-1:0] c3,
   input  logic signed [CW-1:0] c4,
   output logic signed [OW-1:0] out
);
   logic [AW-1:0] r_addr;
   logic [2:0]    r_ph;
   sample_t       r_x [NTAP];
   acc_t          r_acc;
   acc_t          r_out;
   sample_t       w_mem_data;
   coef_t         w_coef;
   sample_t       w_tap;
   prod_t         w_prod;
   acc_t          w_sum;

   direct_input_mem DIRECT_INPUT_MEM (
      .i_addr (r_addr),
      .o_data (w_mem_data)
   );

   // Phase 0 multiplies the oldest tap; phases 1..4 walk c0*x0 .. c3*x3.
   always_comb begin
      w_coef = c4;
      w_tap  = r_x[4];
      case (r_ph)
         3'd0:    begin w_coef = c4; w_tap = r_x[4]; end
         3'd1:    begin w_coef = c0; w_tap = r_x[0]; end
         3'd2:    begin w_coef = c1; w_tap = r_x[1]; end
         3'd3:    begin w_coef = c2; w_tap = r_x[2]; end
         3'd4:    begin w_coef = c3; w_tap = r_x[3]; end
         default: begin w_coef = c4; w_tap = r_x[4]; end
      endcase
      w_prod = prod_t'(w_coef) * prod_t'(w_tap);
      w_sum  = r_acc + prod_to_acc(w_prod);
   end

   // Phase counter, sample history, accumulator and output register.
   always_ff @(posedge clk100) begin
      if (rst) begin
         r_ph   <= 3'd0;
         r_addr <= {AW{1'b0}};
         r_acc  <= {OW{1'b0}};
         r_out  <= {OW{1'b0}};
         for (int k = 0; k < NTAP; k++) begin
            r_x[k] <= {DW{1'b0}};
         end
      end else if (r_ph == 3'd0) begin
         r_x[0] <= w_mem_data;
         for (int k = 1; k < NTAP; k++) begin
            r_x[k] <= r_x[k-1];
         end
         r_addr <= r_addr + 8'd1;
         r_out  <= w_sum;
         r_acc  <= {OW{1'b0}};
         r_ph   <= 3'd1;
      end else begin
         r_acc <= w_sum;
         r_ph  <= (r_ph == 3'd4) ? 3'd0 : r_ph + 3'd1;
      end
   end

   assign out = r_out;
endmodule

// File: tb/tb_top_folded_fir.sv
// Self-checking bench for top_folded_fir: fixed vector table, hand-written
// reset/wrap sequences, and a randomized run against an arithmetic model.
module tb_top_folded_fir;
   logic                clk100 = 1'b0;
   logic                rst    = 1'b1;
   logic signed [11:0]  c0, c1, c2, c3, c4;
   logic signed [21:0]  out;

   int checks = 0;
   int errors = 0;
   int e      = -1;
   int mem_m [256];
   int cf [5];

   typedef struct {
      int    pat;
      int    edge_no;
      int    expv;
      string nm;
   } vec_t;
   vec_t vecs [17];

   always #5 clk100 = ~clk100;

   top_folded_fir dut (
      .clk100 (clk100),
      .rst    (rst),
      .c0     (c0),
      .c1     (c1),
      .c2     (c2),
      .c3     (c3),
      .c4     (c4),
      .out    (out)
   );

   task automatic check(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, e, act, expv);
      end
   endtask

   task automatic set_coefs(input int a, input int b, input int c, input int d, input int f);
      cf[0] = a; cf[1] = b; cf[2] = c; cf[3] = d; cf[4] = f;
      c0 = 12'(a); c1 = 12'(b); c2 = 12'(c); c3 = 12'(d); c4 = 12'(f);
   endtask

   // y[n] = sum c_k * x[n-k]; out at edge e carries y[e/5 - 1], zero before any sample.
   function automatic int ref_out(input int edge_no);
      int n;
      int acc;
      if (edge_no < 0) return 0;
      n   = edge_no / 5 - 1;
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         if (n - k >= 0) acc += cf[k] * mem_m[(n - k) % 256];
      end
      return acc;
   endfunction

   task automatic load_pattern(input int p);
      int v;
      for (int i = 0; i < 256; i++) begin
         case (p)
            0:       v = (i == 0) ? 1 : 0;
            1:       v = 127;
            2:       v = -128;
            3:       v = (i == 255) ? 1 : ((i == 0) ? 2 : 0);
            default: v = int'($urandom_range(0, 255)) - 128;
         endcase
         mem_m[i] = v;
         dut.DIRECT_INPUT_MEM.array[i] = 8'(v);
      end
   endtask

   task automatic tick();
      @(posedge clk100);
      #1;
      e++;
   endtask

   task automatic apply_reset();
      @(negedge clk100);
      rst = 1'b1;
      @(posedge clk100);
      @(posedge clk100);
      #1;
      check("reset", int'(out), 0);
      @(negedge clk100);
      rst = 1'b0;
      e   = -1;
   endtask

   task automatic run_to(input int target);
      while (e < target) tick();
   endtask

   task automatic run_model(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         tick();
         check(nm, int'(out), ref_out(e));
      end
   endtask

   initial begin
      vecs[0]  = '{0,  4,       0, "imp_e4"};
      vecs[1]  = '{0,  5,     605, "imp_e5"};
      vecs[2]  = '{0,  7,     605, "imp_hold"};
      vecs[3]  = '{0, 10,    -867, "imp_e10"};
      vecs[4]  = '{0, 15,    1053, "imp_e15"};
      vecs[5]  = '{0, 20,    -864, "imp_e20"};
      vecs[6]  = '{0, 25,    1618, "imp_e25"};
      vecs[7]  = '{0, 30,       0, "imp_e30"};
      vecs[8]  = '{0, 34,       0, "imp_e34"};
      vecs[9]  = '{1,  5,   76835, "step_e5"};
      vecs[10] = '{1, 10,  -33274, "step_e10"};
      vecs[11] = '{1, 15,  100457, "step_e15"};
      vecs[12] = '{1, 20,   -9271, "step_e20"};
      vecs[13] = '{1, 25,  196215, "step_e25"};
      vecs[14] = '{1, 40,  196215, "step_e40"};
      vecs[15] = '{2, 25, -197760, "neg_e25"};
      vecs[16] = '{2, 45, -197760, "neg_e45"};

      set_coefs(605, -867, 1053, -864, 1618);

      for (int i = 0; i < 17; i++) begin
         load_pattern(vecs[i].pat);
         apply_reset();
         run_to(vecs[i].edge_no);
         check(vecs[i].nm, int'(out), vecs[i].expv);
      end

      // Reset sampled at edge 12 of the impulse run: partial sum is discarded.
      load_pattern(0);
      apply_reset();
      run_model(12, "imp_pre");
      @(negedge clk100);
      rst = 1'b1;
      @(posedge clk100);
      #1;
      check("mid_reset", int'(out), 0);
      @(negedge clk100);
      rst = 1'b0;
      e   = -1;
      run_model(5, "restart_zero");
      run_to(5);
      check("restart_605", int'(out), 605);
      run_model(25, "restart");

      // Address wrap: mem[255] emerges at edge 1280, followed by mem[0] reloaded.
      load_pattern(3);
      apply_reset();
      run_model(1281, "wrap_model");
      check("wrap_e1280", int'(out), 605);
      run_to(1285);
      check("wrap_e1285", int'(out), 343);

      // Random samples and coefficients against the arithmetic model.
      for (int r = 0; r < 2; r++) begin
         set_coefs(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                   int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                   int'($urandom_range(0, 4095)) - 2048);
         load_pattern(4);
         apply_reset();
         run_model(1300, "random");
      end

      // Extreme coefficients with full-scale negative samples: largest magnitude.
      set_coefs(-2048, -2048, -2048, -2048, -2048);
      load_pattern(2);
      apply_reset();
      run_model(40, "max_mag");
      check("max_mag_val", int'(out), 1310720);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
